// File: rtl/mem2d_stream_reader.sv
// rtl/mem2d_stream_reader.sv - ROWSxCOLS register array, random-access write, row-major valid/ready scan (optional MEM2D_OOR_ERR_EN)
module mem2d_stream_reader #(
    parameter int W    = 8,
    parameter int ROWS = 2,
    parameter int COLS = 4,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_row,
    input  logic [AW-1:0] wr_col,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] out_row,
`ifdef MEM2D_OOR_ERR_EN
    output logic          oor_err,
`endif
    output logic [AW-1:0] out_col
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);

    state_t state, state_nxt;
    logic [W-1:0] mem [ROWS][COLS];
    logic in_range, wr_ok, start_ok, xfer, last_xfer;

    assign in_range  = (wr_row < AW'(ROWS)) && (wr_col < AW'(COLS));
    assign wr_ok     = (state == IDLE) && wr_en && in_range;
    assign start_ok  = (state == IDLE) && start;
    assign xfer      = (state == STREAM) && out_ready;
    assign last_xfer = xfer && (out_row == LAST_ROW) && (out_col == LAST_COL);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (last_xfer) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == STREAM);
        out_valid = (state == STREAM);
        done      = (state == DONE);
    end

    // Writes are only honoured in IDLE so the presented entry cannot change under backpressure.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] <= '0;
        end else if (wr_ok) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (wr_row == AW'(r) && wr_col == AW'(c))
                        mem[r][c] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_row <= '0;
            out_col <= '0;
        end else if (start_ok) begin
            out_row <= '0;
            out_col <= '0;
        end else if (xfer) begin
            if (out_col == LAST_COL) begin
                out_col <= '0;
                out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (out_row == AW'(r) && out_col == AW'(c))
                    out_data = mem[r][c];
    end

`ifdef MEM2D_OOR_ERR_EN
    // A fresh out-of-range write wins over the clear from an accepted start.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            oor_err <= 1'b0;
        end else if ((state == IDLE) && wr_en && !in_range) begin
            oor_err <= 1'b1;
        end else if (start_ok) begin
            oor_err <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/mem2d_stream_reader.md
# mem2d_stream_reader

Two-dimensional register-array stage: a ROWS×COLS array of W-bit entries is loaded through a random-access write port and streamed out in row-major order over a valid/ready interface. The block feeds the downstream memory-consuming logic, and out-of-range indices are rejected rather than aliased. Default geometry is a 2×4 array of bytes.

## Interface
- `W`, 8, entry width in bits
- `ROWS`, 2, number of rows
- `COLS`, 4, number of columns
- `AW`, 4, index width for row and column; must satisfy 2^AW > max(ROWS, COLS) so that out-of-range indices are representable
- `clk`  in  1  clock; all state updates on the rising edge
- `nreset`  in  1  reset; one clock, asynchronous assertion, active-low
- `wr_en`  in  1  write strobe
- `wr_row`  in  AW  write row index
- `wr_col`  in  AW  write column index
- `wr_data`  in  W  write data
- `start`  in  1  request a full-array scan
- `busy`  out  1  high from the scan-start edge until the done edge
- `done`  out  1  one-cycle pulse after the last entry is accepted
- `out_valid`  out  1  stream data valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  W  entry at (`out_row`, `out_col`)
- `out_row`  out  AW  row index of the presented entry
- `out_col`  out  AW  column index of the presented entry
- `oor_err`  out  1  sticky out-of-range write flag; present only with `MEM2D_OOR_ERR_EN`

## Operation
- **Reset values.**
  - All array entries are 0.
  - FSM is in IDLE.
  - `busy`, `done`, `out_valid`, `out_row`, `out_col`, `out_data` and `oor_err` are all 0.
- **Write.**
  - In IDLE, a write with `wr_en`=1, `wr_row`<ROWS and `wr_col`<COLS stores `wr_data` at the clock edge.
  - A write with an index ≥ ROWS or ≥ COLS is dropped; no entry changes.
  - `wr_en` is ignored while `busy`=1, so presented data is stable under backpressure.
- **FSM states.**
  - IDLE: on `start`=1, go to STREAM with index (0,0).
  - STREAM: `out_valid`=1. On `out_valid`&&`out_ready`, the column increments; when col=COLS-1 it wraps to 0 and the row increments. When row=ROWS-1 and col=COLS-1, go to DONE.
  - DONE: `done`=1 and `out_valid`=0 for exactly one cycle, then return to IDLE.
- **Stream output.**
  - `out_data` is the array entry at the current index.
  - `out_data`, `out_row` and `out_col` stay stable while `out_valid`=1 and `out_ready`=0.
- **Start handling.** `start` in STREAM or DONE is ignored; it is not queued.
- **Write and start in the same IDLE cycle.** The write commits at that edge and the scan includes the new value.
- **Reset mid-scan.** Asserting `nreset` returns every output and array entry to its reset value immediately; no `done` pulse is produced.

## Timing
- `start` is sampled at edge n. `busy` and `out_valid` are high in the cycle after edge n, presenting entry (0,0).
- One entry transfers per cycle while `out_ready`=1.
- With `out_ready` held at 1, the scan occupies ROWS·COLS STREAM cycles plus 1 DONE cycle. For the default geometry: 8 transfers, then `done` in cycle 9 after start is sampled.
- A new `start` is accepted no earlier than the first IDLE cycle after DONE.
- A write is visible to a scan whose `start` is sampled at the same edge or later.

## Configuration
- **`MEM2D_OOR_ERR_EN` defined:**
  - `oor_err` port exists.
  - It is set at the edge of any out-of-range write attempted in IDLE.
  - It holds until reset, or until the edge at which an accepted `start` is sampled; that clear has priority only if no out-of-range write occurs in the same cycle, and if one does, the flag stays set.
- **Not defined:** `oor_err` port and logic are absent, and out-of-range writes are silently dropped.

## Test plan
- Reset, write row 0 = f0,f1,f2,f3 and row 1 = f4,f5,f6,f7, pulse `start` with `out_ready`=1 -> stream f0..f7 with (row,col) (0,0)..(1,3); `done` pulses one cycle after f7 is accepted; `busy` falls with it.
- Write (3,0)=c1 and (4,2)=c3, then scan a freshly reset array -> all 8 outputs are 00; with the macro, `oor_err`=1 after the first write and cleared at `start`.
- During a scan, hold `out_ready`=0 for 5 cycles at index (0,2) -> `out_data`=f2 and the index stay stable; the scan resumes with f3.
- Assert `wr_en` to (0,0)=aa and pulse `start` again during STREAM -> neither has any effect; the next scan still reads f0 at (0,0).
- Assert `nreset` after 3 transfers -> `out_valid`, `busy` and `done` are 0 immediately; a later scan outputs all 00.
- In IDLE, write (1,3)=5a together with `start` -> the eighth output is 5a.
